// File: rtl/pulse_stretch_amisha.sv
// rtl/pulse_stretch_amisha.sv - tick-to-pulse stretcher with retrigger, one-deep request queue and guaranteed low gap
module pulse_stretch_amisha #(
    parameter int LEN_W   = 8,
    parameter int GAP_CYC = 2
) (
    input  logic              clk_amisha,
    input  logic              reset_amisha,
    input  logic              tick_amisha,
    input  logic [LEN_W-1:0]  len_amisha,
    input  logic              retrig_en_amisha,
    output logic              level_amisha,
    output logic              busy_amisha,
    output logic              overrun_amisha,
    output logic [15:0]       pulse_cnt_amisha
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [7:0]       GAP_LOAD = 8'(GAP_CYC);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   hi_cnt_q, hi_cnt_d;
    logic [7:0]         gap_cnt_q, gap_cnt_d;
    logic               pend_q, pend_d;
    logic [LEN_W-1:0]   pend_len_q, pend_len_d;
    logic               armed_q;
    logic               overrun_d;
    logic               start;
    logic               tick_ok;
    logic [LEN_W-1:0]   eff_len;

    // The first edge after reset release only arms the block; ticks there are ignored.
    assign tick_ok = tick_amisha & armed_q;
    assign eff_len = (len_amisha == '0) ? LEN_ONE : len_amisha;

    always_ff @(posedge clk_amisha or negedge reset_amisha) begin
        if (!reset_amisha) begin
            state_q          <= ST_IDLE;
            hi_cnt_q         <= '0;
            gap_cnt_q        <= '0;
            pend_q           <= 1'b0;
            pend_len_q       <= '0;
            armed_q          <= 1'b0;
            level_amisha     <= 1'b0;
            busy_amisha      <= 1'b0;
            overrun_amisha   <= 1'b0;
            pulse_cnt_amisha <= '0;
        end else begin
            state_q          <= state_d;
            hi_cnt_q         <= hi_cnt_d;
            gap_cnt_q        <= gap_cnt_d;
            pend_q           <= pend_d;
            pend_len_q       <= pend_len_d;
            armed_q          <= 1'b1;
            level_amisha     <= (state_d == ST_HIGH);
            busy_amisha      <= (state_d != ST_IDLE) || pend_d;
            overrun_amisha   <= overrun_d;
            pulse_cnt_amisha <= pulse_cnt_amisha + 16'(start);
        end
    end

    always_comb begin
        state_d    = state_q;
        hi_cnt_d   = hi_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        pend_d     = pend_q;
        pend_len_d = pend_len_q;
        overrun_d  = 1'b0;
        start      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tick_ok) begin
                    state_d  = ST_HIGH;
                    hi_cnt_d = eff_len;
                    start    = 1'b1;
                end
            end
            ST_HIGH: begin
                if (tick_ok && retrig_en_amisha) begin
                    hi_cnt_d = eff_len;
                end else begin
                    if (tick_ok) begin
                        if (!pend_q) begin
                            pend_d     = 1'b1;
                            pend_len_d = eff_len;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end
                    if (hi_cnt_q <= LEN_ONE) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = GAP_LOAD;
                    end else begin
                        hi_cnt_d = hi_cnt_q - LEN_ONE;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q <= 8'd1) begin
                    // Last gap cycle: a queued request launches; a fresh tick either
                    // starts directly or takes over the queue slot.
                    if (pend_q) begin
                        state_d  = ST_HIGH;
                        hi_cnt_d = pend_len_q;
                        start    = 1'b1;
                        if (tick_ok) begin
                            pend_len_d = eff_len;
                        end else begin
                            pend_d = 1'b0;
                        end
                    end else if (tick_ok) begin
                        state_d  = ST_HIGH;
                        hi_cnt_d = eff_len;
                        start    = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                    if (tick_ok) begin
                        if (!pend_q) begin
                            pend_d     = 1'b1;
                            pend_len_d = eff_len;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pulse_stretch_amisha.sv
// tb/tb_pulse_stretch_amisha.sv - scoreboard bench for pulse_stretch_amisha against a remaining-cycles reference model
module tb_pulse_stretch_amisha;

    localparam int GAP_CYC = 2;

    logic        clk_amisha = 1'b0;
    logic        reset_amisha;
    logic        tick_amisha;
    logic [7:0]  len_amisha;
    logic        retrig_en_amisha;
    logic        level_amisha;
    logic        busy_amisha;
    logic        overrun_amisha;
    logic [15:0] pulse_cnt_amisha;

    pulse_stretch_amisha #(.LEN_W(8), .GAP_CYC(GAP_CYC)) dut (
        .clk_amisha       (clk_amisha),
        .reset_amisha     (reset_amisha),
        .tick_amisha      (tick_amisha),
        .len_amisha       (len_amisha),
        .retrig_en_amisha (retrig_en_amisha),
        .level_amisha     (level_amisha),
        .busy_amisha      (busy_amisha),
        .overrun_amisha   (overrun_amisha),
        .pulse_cnt_amisha (pulse_cnt_amisha)
    );

    always #5 clk_amisha = ~clk_amisha;

    int vectors = 0;
    int miscompares = 0;
    int cyc_no = 0;

    logic [18:0] exp_q[$];

    // Reference model: cycles of high / gap still to go, plus one queued request.
    int          hi_left = 0;
    int          gap_left = 0;
    bit          m_pend = 0;
    int          m_plen = 0;
    bit          m_armed = 0;
    bit          m_ovr = 0;
    logic [15:0] m_cnt = '0;

    task automatic queue_or_drop(input int l);
        if (!m_pend) begin
            m_pend = 1;
            m_plen = l;
        end else begin
            m_ovr = 1;
        end
    endtask

    task automatic cyc(input logic rst, input logic tk, input int len, input logic rt);
        bit t;
        int l;
        reset_amisha     = rst;
        tick_amisha      = tk;
        len_amisha       = 8'(len);
        retrig_en_amisha = rt;
        m_ovr = 0;
        if (!rst) begin
            hi_left = 0; gap_left = 0; m_pend = 0; m_plen = 0; m_armed = 0; m_cnt = '0;
        end else begin
            t = tk && m_armed;
            l = (len == 0) ? 1 : len;
            m_armed = 1;
            if (hi_left > 0) begin
                if (t && rt) begin
                    hi_left = l;
                end else begin
                    if (t) queue_or_drop(l);
                    hi_left = hi_left - 1;
                    if (hi_left == 0) gap_left = GAP_CYC;
                end
            end else if (gap_left > 1) begin
                gap_left = gap_left - 1;
                if (t) queue_or_drop(l);
            end else if (gap_left == 1) begin
                gap_left = 0;
                if (m_pend) begin
                    hi_left = m_plen;
                    m_cnt = m_cnt + 16'd1;
                    if (t) m_plen = l;
                    else m_pend = 0;
                end else if (t) begin
                    hi_left = l;
                    m_cnt = m_cnt + 16'd1;
                end
            end else if (t) begin
                hi_left = l;
                m_cnt = m_cnt + 16'd1;
            end
        end
        exp_q.push_back({hi_left > 0, (hi_left > 0) || (gap_left > 0) || m_pend, m_ovr, m_cnt});
        @(negedge clk_amisha);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 0, 1'b0);
    endtask

    task automatic check_now(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Monitor: per-cycle scoreboard plus an independent minimum-low-gap property.
    bit prev_level = 0;
    bit seen_fall = 0;
    int low_run = 0;
    initial begin
        logic [18:0] e;
        forever begin
            @(negedge clk_amisha);
            cyc_no++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if ({level_amisha, busy_amisha, overrun_amisha, pulse_cnt_amisha} !== e) begin
                    miscompares++;
                    $display("FAIL outputs cyc=%0d got lvl=%b busy=%b ovr=%b cnt=%0h want lvl=%b busy=%b ovr=%b cnt=%0h",
                             cyc_no, level_amisha, busy_amisha, overrun_amisha, pulse_cnt_amisha,
                             e[18], e[17], e[16], e[15:0]);
                end
            end
            if (!reset_amisha) begin
                prev_level = 0;
                seen_fall = 0;
                low_run = 0;
            end else begin
                if (level_amisha && !prev_level && seen_fall) begin
                    vectors++;
                    if (low_run < GAP_CYC) begin
                        miscompares++;
                        $display("FAIL min_gap cyc=%0d low=%0d want>=%0d", cyc_no, low_run, GAP_CYC);
                    end
                end
                if (!level_amisha && prev_level) begin
                    seen_fall = 1;
                    low_run = 0;
                end
                if (!level_amisha) low_run++;
                prev_level = level_amisha;
            end
        end
    end

    initial begin
        reset_amisha = 1'b0; tick_amisha = 1'b0; len_amisha = '0; retrig_en_amisha = 1'b0;
        @(negedge clk_amisha);
        #1;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 3, 1'b0);
        // Tick in the first cycle after release must be ignored.
        cyc(1'b1, 1'b1, 4, 1'b0);
        idle(3);
        cyc(1'b1, 1'b1, 5, 1'b0);
        idle(10);
        cyc(1'b1, 1'b1, 0, 1'b0);
        idle(5);
        cyc(1'b1, 1'b1, 255, 1'b0);
        idle(260);
        // Retrigger in high cycle 3.
        cyc(1'b1, 1'b1, 4, 1'b1);
        idle(2);
        cyc(1'b1, 1'b1, 6, 1'b1);
        idle(12);
        // Queued request, then a dropped third tick.
        cyc(1'b1, 1'b1, 3, 1'b0);
        cyc(1'b1, 1'b1, 2, 1'b0);
        cyc(1'b1, 1'b1, 7, 1'b0);
        idle(12);
        // Tick in the last gap cycle, without and with a queued request.
        cyc(1'b1, 1'b1, 1, 1'b0);
        idle(2);
        cyc(1'b1, 1'b1, 2, 1'b0);
        idle(10);
        cyc(1'b1, 1'b1, 1, 1'b0);
        cyc(1'b1, 1'b1, 2, 1'b0);
        idle(1);
        cyc(1'b1, 1'b1, 3, 1'b0);
        idle(15);
        // Reset mid-high with a queued request.
        cyc(1'b1, 1'b1, 10, 1'b0);
        cyc(1'b1, 1'b1, 3, 1'b0);
        idle(2);
        reset_amisha = 1'b0;
        #1;
        check_now("async_reset_level", 32'(level_amisha), 32'd0);
        check_now("async_reset_busy", 32'(busy_amisha), 32'd0);
        cyc(1'b0, 1'b0, 0, 1'b0);
        cyc(1'b0, 1'b0, 0, 1'b0);
        idle(25);
        // Counter wrap from a preloaded 0xFFFF.
        force dut.pulse_cnt_amisha = 16'hFFFF;
        #1;
        release dut.pulse_cnt_amisha;
        m_cnt = 16'hFFFF;
        cyc(1'b1, 1'b1, 1, 1'b0);
        idle(5);
        check_now("cnt_wrap", 32'(pulse_cnt_amisha), 32'd0);
        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) != 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 6)),
                1'($urandom_range(0, 1)));
        end
        idle(10);
        @(negedge clk_amisha);
        #2;
        check_now("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
